// File: rtl/mash_sdm_if.sv
// Control/data bundle for the MASH 1-1-1 sigma-delta modulator.
// The bench side drives EN/alpha/load; the modulator drives out/out_valid/QNC.
interface mash_sdm_if #(
    parameter int N = 10
);
    logic         EN;
    logic [N-1:0] alpha;
    logic         load;
    logic [3:0]   out;
    logic         out_valid;
    logic [N-1:0] QNC;

    modport master (
        output EN, alpha, load,
        input  out, out_valid, QNC
    );

    modport slave (
        input  EN, alpha, load,
        output out, out_valid, QNC
    );
endinterface

// File: rtl/mash_sdm.sv
// MASH 1-1-1 sigma-delta modulator (order 1..3) for the fractional-N divider.
// Optional LSB dither from a 15-bit LFSR is enabled with `define MASH_DITHER_EN.
module mash_sdm #(
    parameter int N     = 10,
    parameter int ORDER = 3
) (
    input  logic       CLK,
    input  logic       RST,
    mash_sdm_if.slave  bus
);

    if ((ORDER < 1) || (ORDER > 3)) begin : g_bad_order
        $error("mash_sdm: ORDER must be 1, 2 or 3");
    end
    if ((N < 4) || (N > 24)) begin : g_bad_width
        $error("mash_sdm: N must be in 4..24");
    end

    logic [N-1:0] f_q;
    logic [N-1:0] acc1_q, acc2_q, acc3_q;
    logic         c2_dly1_q, c3_dly1_q, c3_dly2_q;
    logic [3:0]   out_q;
    logic         valid_q;
    logic [N-1:0] qnc_q;

    logic [N:0]   s1, s2, s3;
    logic         c1, c2, c3;
    logic         dith;
    logic [3:0]   y;

`ifdef MASH_DITHER_EN
    logic [14:0]  lfsr_q;
`endif

    always_comb begin
        dith = 1'b0;
`ifdef MASH_DITHER_EN
        dith = lfsr_q[0] & (f_q != '0);
`endif
        s1 = {1'b0, acc1_q} + {1'b0, f_q} + {{N{1'b0}}, dith};
        s2 = '0;
        s3 = '0;
        // Stages above ORDER stay at zero so their carries never contribute.
        if (ORDER >= 2) s2 = {1'b0, acc2_q} + {1'b0, s1[N-1:0]};
        if (ORDER >= 3) s3 = {1'b0, acc3_q} + {1'b0, s2[N-1:0]};
        c1 = s1[N];
        c2 = s2[N];
        c3 = s3[N];
        y  = 4'(c1) + 4'(c2) - 4'(c2_dly1_q)
           + 4'(c3) - 4'({c3_dly1_q, 1'b0}) + 4'(c3_dly2_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            f_q       <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            acc3_q    <= '0;
            c2_dly1_q <= 1'b0;
            c3_dly1_q <= 1'b0;
            c3_dly2_q <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            qnc_q     <= '0;
`ifdef MASH_DITHER_EN
            lfsr_q    <= 15'h0001;
`endif
        end else begin
            if (bus.load) f_q <= bus.alpha;
            valid_q <= bus.EN;
            if (bus.EN) begin
`ifdef MASH_DITHER_EN
                lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`endif
                // A zero word parks the modulator in a clean all-zero state.
                if (f_q == '0) begin
                    acc1_q    <= '0;
                    acc2_q    <= '0;
                    acc3_q    <= '0;
                    c2_dly1_q <= 1'b0;
                    c3_dly1_q <= 1'b0;
                    c3_dly2_q <= 1'b0;
                    out_q     <= '0;
                    qnc_q     <= '0;
                end else begin
                    acc1_q    <= s1[N-1:0];
                    acc2_q    <= s2[N-1:0];
                    acc3_q    <= s3[N-1:0];
                    c2_dly1_q <= c2;
                    c3_dly1_q <= c3;
                    c3_dly2_q <= c3_dly1_q;
                    out_q     <= y;
                    qnc_q     <= s1[N-1:0];
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.QNC       = qnc_q;

endmodule

// File: tb/tb_mash_sdm.sv
// Scoreboard bench for mash_sdm: three instances (ORDER 1, 2, 3) share one stimulus stream.
module tb_mash_sdm;
    localparam int N = 10;
    localparam int M = 1 << N;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mash_sdm_if #(.N(N)) bus1 ();
    mash_sdm_if #(.N(N)) bus2 ();
    mash_sdm_if #(.N(N)) bus3 ();

    mash_sdm #(.N(N), .ORDER(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    mash_sdm #(.N(N), .ORDER(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));
    mash_sdm #(.N(N), .ORDER(3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

    typedef struct {
        int out;
        int valid;
        int qnc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int n_total = 0;
    int n_bad   = 0;

    int m_f[3], m_a1[3], m_a2[3], m_a3[3];
    int m_c2d1[3], m_c3d1[3], m_c3d2[3];
    int m_out[3], m_val[3], m_qnc[3];

    int g_out[3], g_val[3], g_qnc[3];

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit en,
                              input bit ld, input int a, output exp_t e);
        int o, s, c1, c2, c3, y;
        o = i + 1;
        if (rst) begin
            m_f[i] = 0; m_a1[i] = 0; m_a2[i] = 0; m_a3[i] = 0;
            m_c2d1[i] = 0; m_c3d1[i] = 0; m_c3d2[i] = 0;
            m_out[i] = 0; m_val[i] = 0; m_qnc[i] = 0;
        end else begin
            m_val[i] = en ? 1 : 0;
            if (en) begin
                if (m_f[i] == 0) begin
                    m_a1[i] = 0; m_a2[i] = 0; m_a3[i] = 0;
                    m_c2d1[i] = 0; m_c3d1[i] = 0; m_c3d2[i] = 0;
                    m_out[i] = 0; m_qnc[i] = 0;
                end else begin
                    s = m_a1[i] + m_f[i]; c1 = s / M; m_a1[i] = s % M;
                    c2 = 0; c3 = 0;
                    if (o >= 2) begin s = m_a2[i] + m_a1[i]; c2 = s / M; m_a2[i] = s % M; end
                    if (o >= 3) begin s = m_a3[i] + m_a2[i]; c3 = s / M; m_a3[i] = s % M; end
                    y = c1 + c2 - m_c2d1[i] + c3 - 2 * m_c3d1[i] + m_c3d2[i];
                    m_c3d2[i] = m_c3d1[i];
                    m_c3d1[i] = c3;
                    m_c2d1[i] = c2;
                    m_out[i]  = y;
                    m_qnc[i]  = m_a1[i];
                end
            end
            if (ld) m_f[i] = a;
        end
        e.out   = m_out[i];
        e.valid = m_val[i];
        e.qnc   = m_qnc[i];
    endtask

    task automatic tick(input bit rst, input bit en, input bit ld, input int a);
        exp_t e;
        logic [31:0] av;
        av = a;
        @(negedge CLK);
        RST = rst;
        bus1.EN = en; bus1.load = ld; bus1.alpha = av[N-1:0];
        bus2.EN = en; bus2.load = ld; bus2.alpha = av[N-1:0];
        bus3.EN = en; bus3.load = ld; bus3.alpha = av[N-1:0];
        model_step(0, rst, en, ld, a, e); sb0.push_back(e);
        model_step(1, rst, en, ld, a, e); sb1.push_back(e);
        model_step(2, rst, en, ld, a, e); sb2.push_back(e);
        @(posedge CLK);
        #1;
        g_out[0] = int'($signed(bus1.out)); g_val[0] = int'(bus1.out_valid); g_qnc[0] = int'(bus1.QNC);
        g_out[1] = int'($signed(bus2.out)); g_val[1] = int'(bus2.out_valid); g_qnc[1] = int'(bus2.QNC);
        g_out[2] = int'($signed(bus3.out)); g_val[2] = int'(bus3.out_valid); g_qnc[2] = int'(bus3.QNC);
        e = sb0.pop_front();
        chk("o1_out", g_out[0], e.out); chk("o1_valid", g_val[0], e.valid); chk("o1_qnc", g_qnc[0], e.qnc);
        e = sb1.pop_front();
        chk("o2_out", g_out[1], e.out); chk("o2_valid", g_val[1], e.valid); chk("o2_qnc", g_qnc[1], e.qnc);
        e = sb2.pop_front();
        chk("o3_out", g_out[2], e.out); chk("o3_valid", g_val[2], e.valid); chk("o3_qnc", g_qnc[2], e.qnc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sum, viol;
        bit pat[8];
        bus1.EN = 0; bus1.load = 0; bus1.alpha = '0;
        bus2.EN = 0; bus2.load = 0; bus2.alpha = '0;
        bus3.EN = 0; bus3.load = 0; bus3.alpha = '0;

        // reset state
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out", g_out[i], 0);
            chk("rst_valid", g_val[i], 0);
            chk("rst_qnc", g_qnc[i], 0);
        end

        // ORDER 1, F=512: 0,1,0,1 with QNC 512,0
        tick(0, 0, 1, 512);
        for (int k = 0; k < 8; k++) begin
            tick(0, 1, 0, 0);
            chk("ord1_alt_out", g_out[0], k % 2);
            chk("ord1_alt_qnc", g_qnc[0], (k % 2 == 0) ? 512 : 0);
        end

        // ORDER 3, F=300, 1024 steps: range and average
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 300);
        sum = 0; viol = 0;
        for (int k = 0; k < 1024; k++) begin
            tick(0, 1, 0, 0);
            sum += g_out[2];
            if (g_out[2] < -3 || g_out[2] > 4) viol++;
        end
        chk("ord3_range_viol", viol, 0);
        chk("ord3_sum_in_299_302", (sum >= 299 && sum <= 302) ? 1 : 0, 1);

        // ORDER 2 zero-input rule
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 1);
        for (int k = 0; k < 5; k++) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 0, 0);
            chk("zero_out", g_out[1], 0);
            chk("zero_valid", g_val[1], 1);
            chk("zero_qnc", g_qnc[1], 0);
        end

        // EN gating with F=700
        pat = '{1, 0, 0, 1, 1, 0, 1, 1};
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 700);
        for (int k = 0; k < 24; k++) begin
            tick(0, pat[k % 8], 0, 0);
            chk("gate_valid", g_val[2], int'(pat[k % 8]));
        end

        // load together with EN: old F on that step
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 256);
        tick(0, 1, 1, 768);
        chk("ldsame_qnc0", g_qnc[2], 256);
        tick(0, 1, 0, 0);
        chk("ldsame_qnc1", g_qnc[2], 0);
        tick(0, 1, 0, 0);
        chk("ldsame_qnc2", g_qnc[2], 768);
        tick(0, 1, 0, 0);
        chk("ldsame_qnc3", g_qnc[2], 512);

        // reset mid-run at step 37, then a fresh run
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 300);
        for (int k = 0; k < 36; k++) tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_out", g_out[i], 0);
            chk("midrst_valid", g_val[i], 0);
            chk("midrst_qnc", g_qnc[i], 0);
        end
        tick(0, 0, 1, 300);
        for (int k = 0; k < 20; k++) tick(0, 1, 0, 0);
        chk("fresh_qnc_after20", g_qnc[2], (20 * 300) % M);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mash_sdm.md
# mash_sdm

Parametrised MASH 1-1-1 sigma-delta modulator that converts an N-bit unsigned fractional word into a multi-bit signed integer stream for the fractional-N divider of the PLL model. The long-run average of the stream equals F/2^N. It replaces the single-bit second-order modulator with three things:
- a selectable order (1 to 3),
- a double-buffered fractional word,
- clock-enable gating with a valid strobe.

## Interface
- N, 10: fractional word and accumulator width (4..24).
- ORDER, 3: modulator order (1, 2 or 3); any other value is an elaboration error.
- CLK  input  1  system clock; all logic updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  advance the modulator by one step this cycle.
- alpha  input  N  unsigned fractional word F, latched on load.
- load  input  1  write alpha into the shadow register.
- out  output  4  signed divider offset: ORDER 1 gives 0..1, ORDER 2 gives -1..2, ORDER 3 gives -3..4.
- out_valid  output  1  out was updated this cycle.
- QNC  output  N  stage-1 accumulator value (quantisation-noise tap).

## Operation
- Reset values:
  - Shadow register F, acc1..acc3 and the carry delay registers c2_d1, c3_d1 and c3_d2 are 0.
  - out is 0, out_valid is 0 and QNC is 0.
  - RST overrides load and EN in the same cycle.
- Load:
  - On a load edge, F <= alpha; this is independent of EN.
  - The new F is used from the next enabled step.
  - Accumulators are not cleared on load.
- Step (EN=1, F≠0). All sums are N+1 bits, the carry is bit N, and the accumulator keeps bits N-1:0, so it wraps modulo 2^N.
  - s1 = acc1 + F (+ dither, see Configuration); c1 = s1[N]; acc1' = s1[N-1:0].
  - s2 = acc2 + acc1'; c2 = s2[N].
  - s3 = acc3 + acc2'; c3 = s3[N].
  - Stages above ORDER are held at 0 and their carries are 0.
- Noise cancellation, signed 4-bit:
  - y = c1 + (c2 − c2_d1) + (c3 − 2·c3_d1 + c3_d2).
  - Delay registers shift on enabled steps only.
- Registers updated on an enabled step: out <= y, out_valid <= 1, QNC <= acc1'.
- EN=0: all state and out hold; out_valid <= 0.
- F=0 with EN=1 (the zero-input rule):
  - acc1..3 and all delay registers clear to 0.
  - out <= 0 and out_valid <= 1.
  - No carries are produced.
- Reset mid-run returns every register to its reset value on that edge; the next enabled step starts from zero state.

## Timing
- Latency: an enabled edge samples F and current state, and out/out_valid show the result directly after that edge (1 cycle).
- The noise-cancel network is combinational between the accumulators and the out register; there is no extra pipeline stage.
- Load-to-effect: a load on edge k affects the y computed on edge k+1 or later, whichever is the first enabled edge.
- Simultaneous load and EN on the same edge: the step uses the old F.
- out_valid is a registered copy of EN when RST=0.

## Configuration
- MASH_DITHER_EN defined:
  - A 15-bit Fibonacci LFSR (x^15+x^14+1, reset seed 15'h0001) advances on each enabled step.
  - Its bit 0 is added to s1 as an LSB dither.
  - Dither is suppressed when F=0.
  - Output stays within the ORDER range, and the mean shifts by at most 2^-(N+1).
- MASH_DITHER_EN undefined: no LFSR, and s1 = acc1 + F exactly.

## Test plan
- ORDER=1, N=10, F=512, EN held 1 after reset -> out sequence 0,1,0,1,…; QNC alternates 512,0.
- ORDER=3, N=10, F=300, 1024 enabled steps from reset -> every out in −3..4; Σout in [299, 302].
- ORDER=2, F=1 then load F=0 -> on the step after the load, acc1..acc3 are 0 and out is 0 thereafter, with out_valid=1.
- EN toggled 1,0,0,1 with F=700 -> out and QNC hold during the two EN=0 cycles; out_valid pattern is 1,0,0,1; the sequence is identical to an ungated run with idle cycles removed.
- Load with EN same edge, F 256→768 -> the first step uses 256, and from the next step QNC increments by 768 mod 1024.
- RST asserted mid-run at step 37 -> out=0, out_valid=0, QNC=0 on that edge; the subsequent sequence matches a fresh post-reset run.
